// File: rtl/tff_lockstep_monitor_if.sv
// Bundle between the lockstep monitor and whatever drives/observes it.
// Carries the monitor control inputs (en, clear), the shared toggle input t,
// the three flip-flop outputs under check and every status output of the
// monitor. clk and reset stay plain ports on the monitor itself.
//   master : driver/observer side (bench or debug register bank)
//   slave  : monitor side
interface tff_lockstep_monitor_if #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
);
    logic             en;
    logic             clear;
    logic             t;
    logic             q_jk;
    logic             q_sr;
    logic             q_d;
    logic [1:0]       state;
    logic [2:0]       err;
    logic             err_any;
    logic [2:0]       first_src;
    logic [CYC_W-1:0] first_cyc;
    logic [CNT_W-1:0] mis_jk;
    logic [CNT_W-1:0] mis_sr;
    logic [CNT_W-1:0] mis_d;
    logic [CNT_W-1:0] toggle_cnt;
    logic             maj_q;

    modport master (
        output en, clear, t, q_jk, q_sr, q_d,
        input  state, err, err_any, first_src, first_cyc,
               mis_jk, mis_sr, mis_d, toggle_cnt, maj_q
    );

    modport slave (
        input  en, clear, t, q_jk, q_sr, q_d,
        output state, err, err_any, first_src, first_cyc,
               mis_jk, mis_sr, mis_d, toggle_cnt, maj_q
    );
endinterface

// File: rtl/tff_lockstep_monitor.sv
// Lockstep monitor for a three-way T flip-flop block (JK-, SR- and D-based).
// Keeps its own reference T model, compares q_jk/q_sr/q_d against it on
// every edge while armed, counts mismatches and toggles (saturating),
// latches the first failure and provides a registered 2-of-3 vote.
// Ports:
//   clk   : rising-edge clock shared with the flip-flop block
//   reset : asynchronous active-high reset, clears all state
//   mon   : slave side of tff_lockstep_monitor_if (en, clear, t, q_* in;
//           state, err, err_any, first_src, first_cyc, mis_*, toggle_cnt,
//           maj_q out; all outputs are registered)
module tff_lockstep_monitor #(
    parameter int CNT_W      = 8,
    parameter int CYC_W      = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    tff_lockstep_monitor_if.slave  mon
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam int           SET_W    = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC);
    localparam bit           NO_SETTLE = (SETTLE_CYC == 32'sd0);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             q_ref_q;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       err_q, err_d;
    logic             err_any_q;
    logic [2:0]       first_src_q, first_src_d;
    logic [CYC_W-1:0] first_cyc_q, first_cyc_d;
    logic [CNT_W-1:0] mis_jk_q, mis_jk_d;
    logic [CNT_W-1:0] mis_sr_q, mis_sr_d;
    logic [CNT_W-1:0] mis_d_q, mis_d_d;
    logic [CNT_W-1:0] toggle_q, toggle_d;
    logic             maj_vote_q;

    logic [2:0]       mis_s;
    logic             counting_s;
    logic             capture_s;
    logic             arm_s;

    // Pre-edge comparison: both sides were updated on the previous edge.
    assign mis_s = {mon.q_d ^ q_ref_q, mon.q_sr ^ q_ref_q, mon.q_jk ^ q_ref_q};

    // State register plus reference model, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            q_ref_q     <= 1'b0;
            cyc_q       <= '0;
            err_q       <= 3'b000;
            err_any_q   <= 1'b0;
            first_src_q <= 3'b000;
            first_cyc_q <= '0;
            mis_jk_q    <= '0;
            mis_sr_q    <= '0;
            mis_d_q     <= '0;
            toggle_q    <= '0;
            maj_vote_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            q_ref_q     <= q_ref_q ^ mon.t;
            cyc_q       <= cyc_d;
            err_q       <= err_d;
            err_any_q   <= |err_d;
            first_src_q <= first_src_d;
            first_cyc_q <= first_cyc_d;
            mis_jk_q    <= mis_jk_d;
            mis_sr_q    <= mis_sr_d;
            mis_d_q     <= mis_d_d;
            toggle_q    <= toggle_d;
            maj_vote_q  <= maj3(mon.q_jk, mon.q_sr, mon.q_d);
        end
    end

    // Next-state logic: en=0 wins, then clear, then mismatch.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (!mon.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    settle_d = SET_LOAD;
                    if (NO_SETTLE) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // settle_q counts down the remaining suppressed edges
                    if (settle_q <= SET_W'(1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mon.clear) begin
                        state_d = ST_CHECK;
                    end else if (|mis_s) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                ST_FAULT: begin
                    if (mon.clear) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: which datapath action applies at this edge.
    always_comb begin
        arm_s      = mon.en && (state_q == ST_IDLE);
        counting_s = mon.en && !mon.clear &&
                     ((state_q == ST_CHECK) || (state_q == ST_FAULT));
        capture_s  = counting_s && (state_q == ST_CHECK) && (|mis_s);
    end

    // Statistics datapath: clear discards any same-edge mismatch.
    always_comb begin
        cyc_d       = cyc_q;
        err_d       = err_q;
        first_src_d = first_src_q;
        first_cyc_d = first_cyc_q;
        mis_jk_d    = mis_jk_q;
        mis_sr_d    = mis_sr_q;
        mis_d_d     = mis_d_q;
        toggle_d    = toggle_q;
        if (mon.clear) begin
            cyc_d       = '0;
            err_d       = 3'b000;
            first_src_d = 3'b000;
            first_cyc_d = '0;
            mis_jk_d    = '0;
            mis_sr_d    = '0;
            mis_d_d     = '0;
            toggle_d    = '0;
        end else if (counting_s) begin
            cyc_d = sat_inc_cyc(cyc_q);
            err_d = err_q | mis_s;
            if (mis_s[0]) begin
                mis_jk_d = sat_inc_cnt(mis_jk_q);
            end else begin
                mis_jk_d = mis_jk_q;
            end
            if (mis_s[1]) begin
                mis_sr_d = sat_inc_cnt(mis_sr_q);
            end else begin
                mis_sr_d = mis_sr_q;
            end
            if (mis_s[2]) begin
                mis_d_d = sat_inc_cnt(mis_d_q);
            end else begin
                mis_d_d = mis_d_q;
            end
            if (mon.t) begin
                toggle_d = sat_inc_cnt(toggle_q);
            end else begin
                toggle_d = toggle_q;
            end
            if (capture_s) begin
                first_src_d = mis_s;
                first_cyc_d = cyc_q;
            end else begin
                first_src_d = first_src_q;
                first_cyc_d = first_cyc_q;
            end
        end else if (arm_s) begin
            cyc_d = '0;
        end else begin
            cyc_d = cyc_q;
        end
    end

    assign mon.state      = state_q;
    assign mon.err        = err_q;
    assign mon.err_any    = err_any_q;
    assign mon.first_src  = first_src_q;
    assign mon.first_cyc  = first_cyc_q;
    assign mon.mis_jk     = mis_jk_q;
    assign mon.mis_sr     = mis_sr_q;
    assign mon.mis_d      = mis_d_q;
    assign mon.toggle_cnt = toggle_q;
    assign mon.maj_q      = maj_vote_q;
endmodule

// File: doc/tff_lockstep_monitor.md
Name: tff_lockstep_monitor

Overview:
- Downstream consumer of the three-way T flip-flop block (JK-, SR- and D-based implementations sharing one t input).
- Keeps its own reference T model and checks q_jk, q_sr and q_d against it every cycle.
- Counts mismatches per implementation and toggles, latches the first failure, and provides a registered 2-of-3 voted output.
- Sits beside the flip-flop block on the same clk/reset and feeds status to the bench or to a debug register bank.

Parameters:
- CNT_W, 8: width of the per-source mismatch counters and the toggle counter; all saturate.
- CYC_W, 16: width of the check-cycle counter and of first_cyc; saturates.
- SETTLE_CYC, 1: number of edges after arming during which comparison is suppressed; 0 is legal.

Ports:
- clk  in  1  rising-edge clock, shared with the flip-flop block
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  arm the monitor; 0 returns it to IDLE
- clear  in  1  synchronous clear of error and statistics state
- t  in  1  the same toggle input driven into the flip-flop block
- q_jk, q_sr, q_d  in  1 each  outputs of the flip-flop block under check
- state  out  2  IDLE=0, SETTLE=1, CHECK=2, FAULT=3
- err  out  3  sticky per-source error flags {d,sr,jk}
- err_any  out  1  OR of err
- first_src  out  3  mismatch mask captured at the first failure
- first_cyc  out  CYC_W  check-cycle index of the first failure
- mis_jk, mis_sr, mis_d  out  CNT_W each  saturating mismatch counts
- toggle_cnt  out  CNT_W  saturating count of edges sampled with t=1 in CHECK/FAULT
- maj_q  out  1  registered majority vote of q_jk, q_sr, q_d

Behaviour:
- Reset (async, active-high): q_ref=0, state=IDLE, and every output and counter is 0. The flip-flop block also resets its outputs to 0.
- Reference model: q_ref <= q_ref ^ t on every edge, in every state, independent of en.
- Compare at edge k uses pre-edge values. Mismatch vector m = {q_d^q_ref, q_sr^q_ref, q_jk^q_ref}. Both sides were updated at edge k-1, so a healthy DUT gives m=0.
- Results appear in registers after edge k (1-cycle latency). maj_q also has 1-cycle latency.
- IDLE:
  - No checks are made and counters hold.
  - en=1 moves to SETTLE, or directly to CHECK if SETTLE_CYC=0.
  - On entering SETTLE/CHECK from IDLE, the cycle counter cyc is zeroed.
- SETTLE: counts SETTLE_CYC edges with no comparison, then moves to CHECK.
- CHECK:
  - cyc increments each edge and saturates at all-ones.
  - For each set bit of m, the matching mis_* counter increments and the matching err bit sets.
  - If t=1, toggle_cnt increments.
  - If m!=0: first_src<=m, first_cyc<=cyc (pre-increment value), and the state moves to FAULT.
- FAULT: same counting as CHECK. err stays sticky, and first_src/first_cyc are frozen.
- clear=1 at an edge (en=1):
  - err, first_src, first_cyc, mis_*, toggle_cnt and cyc all go to 0.
  - FAULT moves to CHECK; CHECK stays CHECK.
  - Any mismatch sampled on the same edge is discarded.
  - clear has priority over mismatch.
- en=0 at an edge from any state: moves to IDLE. All statistics and err hold, and clear is still honoured.
- Priority at an edge: reset > en=0 > clear > mismatch/count.
- Saturation: counters stop at 2^CNT_W-1 and cyc stops at 2^CYC_W-1. There is no wrap.
- Multiple simultaneous mismatches: every mismatching counter increments in the same edge, and first_src captures the full mask.
- Reset asserted mid-operation: immediate return to all-zero outputs and IDLE. q_ref stays 0 until reset deasserts.

Test Plan:
- Reset sequence, then en=1, SETTLE_CYC=1, t=0 for 4 edges and then t=1 for 4 edges, healthy DUT:
  - state goes 0→1→2.
  - err=0.
  - toggle_cnt=4.
  - maj_q alternates 1,0,1,0 one cycle after each q change.
- Force q_sr inverted for one cycle at check cycle 5:
  - err=3'b010 and state=FAULT.
  - first_src=3'b010, first_cyc=5, mis_sr=1.
  - maj_q remains equal to q_ref.
- Force all three q wrong on the same edge: first_src=3'b111, each mis_* =1, err_any=1.
- In FAULT, assert clear together with a fresh mismatch: state=CHECK, all counters 0, err=0, and the mismatch is not counted.
- CNT_W=2, hold q_d stuck at 0 with t=1 for 10 edges: mis_d saturates at 3, and no other counter is affected except toggle_cnt=3.
- Assert reset asynchronously mid-CHECK, between edges: all outputs are 0 immediately. Deassert, then re-arm: operation is identical to the first scenario.
